// File: rtl/systolic_tile_ctrl.sv
// Tile sequencer for the systolic array: weight load, input streaming, wavefront flush,
// result drain, then a one-cycle done pulse.
module systolic_tile_ctrl #(
   parameter int unsigned ROWS  = 3,
   parameter int unsigned COLS  = 3,
   parameter int unsigned K_MAX = 16,
   parameter int unsigned CW    = $clog2(K_MAX + ROWS + COLS + 1),
   parameter int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
   parameter int unsigned CLW   = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [CW-1:0]   k_len_i,
   input  logic [ROWS-1:0] ib_valid_i,
   output logic            busy_o,
   output logic            w_load_o,
   output logic [RW-1:0]   w_row_o,
   output logic            ib_read_o,
   output logic            acc_clr_o,
   output logic            acc_en_o,
   output logic            drain_valid_o,
   output logic [CLW-1:0]  drain_col_o,
   output logic            done_o,
   output logic            err_o
);

   localparam logic [CW-1:0] RowsLast = CW'(ROWS - 1);
   localparam logic [CW-1:0] ColsLast = CW'(COLS - 1);
   localparam logic [CW-1:0] KMax     = CW'(K_MAX);
   // Last counter value of the minimum flush window (ROWS+COLS-1 cycles).
   localparam logic [CW-1:0] FlushMin = CW'(ROWS + COLS - 2);

   typedef enum logic [2:0] {
      StIdle,
      StWload,
      StStream,
      StFlush,
      StDrain,
      StDone
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] klen_q, klen_d;
   logic          err_q, err_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         klen_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         klen_q  <= klen_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      klen_d  = klen_q;
      err_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               if ((k_len_i == '0) || (k_len_i > KMax)) begin
                  err_d = 1'b1;
               end else begin
                  klen_d  = k_len_i;
                  cnt_d   = '0;
                  state_d = StWload;
               end
            end
         end
         StWload: begin
            if (cnt_q == RowsLast) begin
               cnt_d   = '0;
               state_d = StStream;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StStream: begin
            if (cnt_q == (klen_q - CW'(1))) begin
               cnt_d   = '0;
               state_d = StFlush;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StFlush: begin
            // Counter saturates at the minimum; afterwards only ib_valid holds us here.
            if ((cnt_q >= FlushMin) && (ib_valid_i == '0)) begin
               cnt_d   = '0;
               state_d = StDrain;
            end else if (cnt_q < FlushMin) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StDrain: begin
            if (cnt_q == ColsLast) begin
               cnt_d   = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StDone: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
         default: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      busy_o        = (state_q != StIdle);
      w_load_o      = (state_q == StWload);
      w_row_o       = w_load_o ? RW'(cnt_q) : '0;
      acc_clr_o     = w_load_o && (cnt_q == RowsLast);
      ib_read_o     = (state_q == StStream);
      drain_valid_o = (state_q == StDrain);
      drain_col_o   = drain_valid_o ? CLW'(cnt_q) : '0;
      done_o        = (state_q == StDone);
      err_o         = err_q;
      acc_en_o      = ((state_q == StStream) || (state_q == StFlush)) && (|ib_valid_i);
   end

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Directed bench for systolic_tile_ctrl: per-cycle output vectors checked against a
// hand-derived tile timeline, plus bound, stall, busy-start and async-reset scenarios.
module tb_systolic_tile_ctrl;

   localparam int ROWS  = 3;
   localparam int COLS  = 3;
   localparam int K_MAX = 16;
   localparam int CW    = $clog2(K_MAX + ROWS + COLS + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CW-1:0] k_len;
   logic [2:0]    ib_valid;
   logic          busy, w_load, ib_read, acc_clr, acc_en, drain_valid, done, err;
   logic [1:0]    w_row, drain_col;

   logic [2:0]    rd_sr = 3'b000;
   logic [2:0]    force_v;
   logic          done_prev = 1'b0;
   logic [11:0]   obs;
   int            total = 0;
   int            bad = 0;

   always #5 clk = ~clk;

   systolic_tile_ctrl #(
      .ROWS (ROWS),
      .COLS (COLS),
      .K_MAX(K_MAX)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .k_len_i      (k_len),
      .ib_valid_i   (ib_valid),
      .busy_o       (busy),
      .w_load_o     (w_load),
      .w_row_o      (w_row),
      .ib_read_o    (ib_read),
      .acc_clr_o    (acc_clr),
      .acc_en_o     (acc_en),
      .drain_valid_o(drain_valid),
      .drain_col_o  (drain_col),
      .done_o       (done),
      .err_o        (err)
   );

   // Input-buffer stand-in: lane r goes valid r+1 cycles after each read.
   always @(posedge clk) rd_sr <= {rd_sr[1:0], ib_read};
   assign ib_valid = rd_sr | force_v;

   assign obs = {busy, w_load, w_row, acc_clr, ib_read, acc_en, drain_valid, drain_col, done, err};

   always @(negedge clk) begin
      if (!rst) begin
         assert ($onehot0({w_load, ib_read, drain_valid, done})) else begin
            bad++;
            $error("FAIL onehot observed=%b required=onehot0",
                   {w_load, ib_read, drain_valid, done});
         end
         assert (!acc_en || (busy && !w_load && !drain_valid && !done)) else begin
            bad++;
            $error("FAIL acc_en_window observed=1 required=0");
         end
         assert (!(done && done_prev)) else begin
            bad++;
            $error("FAIL done_width observed=2+ cycles required=1");
         end
      end
      done_prev <= done;
   end

   // Expected outputs for cycle c of a tile started at cycle 0 with fl flush cycles.
   function automatic logic [11:0] exp_vec(input int c, input int k, input int fl,
                                           input logic [2:0] ibv);
      int fs, ds, dn;
      logic bz, wl, ac, rd, ae, dv, dd;
      logic [1:0] wr, dc;
      fs = ROWS + 1 + k;
      ds = fs + fl;
      dn = ds + COLS;
      bz = (c >= 1) && (c <= dn);
      wl = (c >= 1) && (c <= ROWS);
      wr = wl ? 2'(c - 1) : 2'd0;
      ac = (c == ROWS);
      rd = (c >= ROWS + 1) && (c < fs);
      ae = (c >= ROWS + 1) && (c < ds) && (ibv != 3'b000);
      dv = (c >= ds) && (c < dn);
      dc = dv ? 2'(c - ds) : 2'd0;
      dd = (c == dn);
      return {bz, wl, wr, ac, rd, ae, dv, dc, dd, 1'b0};
   endfunction

   task automatic check(input string tag, input int c, input logic [11:0] o,
                        input logic [11:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%b required=%b", tag, c, o, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_tile(input string tag, input int k, input int fl, input int stall_end,
                           input int pulse_c, input bit hold_end, input bit do_start);
      int dn;
      dn = ROWS + 1 + k + fl + COLS;
      if (do_start) begin
         start = 1'b1;
         k_len = CW'(k);
      end
      for (int c = 1; c <= dn + 1; c++) begin
         step();
         if (c == 1) start = 1'b0;
         if (pulse_c != 0 && c == pulse_c) begin
            start = 1'b1;
            k_len = CW'(5);
         end
         if (pulse_c != 0 && c == pulse_c + 1) start = 1'b0;
         if (hold_end && c == dn) begin
            start = 1'b1;
            k_len = CW'(2);
         end
         force_v = (c >= ROWS + 1 + k && c < stall_end) ? 3'b100 : 3'b000;
         #1;
         check(tag, c, obs, exp_vec(c, k, fl, ib_valid));
      end
   endtask

   task automatic run_err(input string tag, input int k);
      start = 1'b1;
      k_len = CW'(k);
      step();
      start = 1'b0;
      #1;
      check(tag, 1, obs, 12'b0000_0000_0001);
      step();
      #1;
      check(tag, 2, obs, 12'b0);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      k_len   = '0;
      force_v = 3'b000;
      #3;
      check("reset_state", 0, obs, 12'b0);
      #9;
      rst = 1'b0;
      #1;
      check("post_reset_idle", 0, obs, 12'b0);
      step();

      run_tile("nominal_k3", 3, 5, 0, 0, 1'b0, 1'b1);
      run_err("err_k0", 0);
      run_err("err_k17", 17);
      run_tile("max_k16", 16, 5, 0, 0, 1'b0, 1'b1);
      run_tile("flush_stall", 3, 7, 13, 0, 1'b0, 1'b1);
      run_tile("busy_start", 3, 5, 0, 5, 1'b1, 1'b1);
      run_tile("held_start_k2", 2, 5, 0, 0, 1'b0, 1'b0);

      // Abandon a tile mid-STREAM with an asynchronous reset between edges.
      start = 1'b1;
      k_len = CW'(3);
      step();
      start = 1'b0;
      for (int c = 2; c <= 5; c++) step();
      #2;
      rst = 1'b1;
      #1;
      check("rst_async", 5, obs, 12'b0);
      step();
      #1;
      check("rst_hold", 6, obs, 12'b0);
      step();
      #2;
      rst = 1'b0;
      step();
      #1;
      check("rst_release_idle", 8, obs, 12'b0);
      step();
      run_tile("post_rst_k2", 2, 5, 0, 0, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
